// File: rtl/button_pkg.sv
// button_pkg: shared constants and helpers for the button_toggle_bank slice.
//   cnt_width()      - counter width for a terminal count (clog2, min 1 bit)
//   released_level() - level a button pin reads when not pressed
//   DEFAULT_*        - cycle counts sized for a 25 MHz board clock
package button_pkg;

  // 10 ms of debounce and 1 s long-press at 25 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 250_000;
  localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 25_000_000;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic released_level(input int unsigned active_low);
    return (active_low != 0) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// button_debounce_ch: one button channel.
//   2-flop synchroniser, stability-counter debounce, registered edge pulses.
// Ports:
//   CLK, RST_N     clock, async active-low reset
//   BUT            raw button pin (asynchronous)
//   stable         debounced level
//   stable_prev    debounced level one clock earlier
//   press_pulse    1-clock pulse after stable goes released->pressed
//   release_pulse  1-clock pulse after stable goes pressed->released
module button_debounce_ch
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BUT,
  output logic stable,
  output logic stable_prev,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic             REL      = released_level(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             synced;
  logic [CNT_W-1:0] cnt;
  logic             press_evt;
  logic             release_evt;

  always_comb begin
    press_evt   = (stable != stable_prev) && (stable != REL);
    release_evt = (stable != stable_prev) && (stable == REL);
  end

  // Everything resets to the released level so a button held through
  // reset must complete a full debounce before it is seen as pressed.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1         <= REL;
      synced        <= REL;
      stable        <= REL;
      stable_prev   <= REL;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= BUT;
      synced        <= sync1;
      stable_prev   <= stable;
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_toggle_bank.sv
// button_toggle_bank: N_CH debounced push-buttons, each toggling one LED.
// Ports:
//   CLK, RST_N  clock, async active-low reset
//   BUT         raw button pins (asynchronous)
//   CLR_ALL     synchronous clear of all LEDs (beats press and long-press)
//   LED         per-channel toggle state
//   PRESS       1-clock pulse per debounced press
//   RELEASE     1-clock pulse per debounced release
//   LONG        1-clock pulse after LONG_PRESS_CYCLES of hold; also clears LED
// Build option: define BUTTON_TOGGLE_BANK_LONG_PRESS_EN to include the
// long-press counters; otherwise LONG is constant 0.
module button_toggle_bank
  import button_pkg::*;
#(
  parameter int unsigned N_CH              = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned ACTIVE_LOW        = 1,
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N_CH-1:0] BUT,
  input  logic            CLR_ALL,
  output logic [N_CH-1:0] LED,
  output logic [N_CH-1:0] PRESS,
  output logic [N_CH-1:0] RELEASE,
  output logic [N_CH-1:0] LONG
);

  localparam logic PRS = ~released_level(ACTIVE_LOW);

  if (N_CH < 1 || DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 1) begin : g_bad_params
    $error("button_toggle_bank: N_CH>=1, DEBOUNCE_CYCLES>=2, LONG_PRESS_CYCLES>=1 required");
  end

  logic [N_CH-1:0] stable;
  logic [N_CH-1:0] stable_prev;
  logic [N_CH-1:0] press_evt;
  logic [N_CH-1:0] long_evt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .BUT          (BUT[i]),
      .stable       (stable[i]),
      .stable_prev  (stable_prev[i]),
      .press_pulse  (PRESS[i]),
      .release_pulse(RELEASE[i])
    );
  end

  // Same condition the channel registers into PRESS, so the LED toggles
  // on the very edge PRESS rises.
  always_comb begin
    press_evt = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      press_evt[i] = (stable[i] == PRS) && (stable_prev[i] != PRS);
    end
  end

`ifdef BUTTON_TOGGLE_BANK_LONG_PRESS_EN
  localparam int unsigned       HOLD_W   = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

  logic [N_CH-1:0][HOLD_W-1:0] hold;

  // Fires on the increment that lands on HOLD_MAX; the counter then
  // saturates, giving one pulse per hold.
  always_comb begin
    long_evt = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      long_evt[i] = (stable[i] == PRS) && !press_evt[i] &&
                    (hold[i] == HOLD_MAX - 1'b1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold <= '0;
      LONG <= '0;
    end else begin
      LONG <= long_evt;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (press_evt[i] || (stable[i] != PRS)) begin
          hold[i] <= '0;
        end else if (hold[i] != HOLD_MAX) begin
          hold[i] <= hold[i] + 1'b1;
        end
      end
    end
  end
`else
  always_comb long_evt = '0;
  assign LONG = '0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LED <= '0;
    end else if (CLR_ALL) begin
      LED <= '0;
    end else begin
      LED <= (LED ^ press_evt) & ~long_evt;
    end
  end

endmodule

// File: tb/tb_button_toggle_bank.sv
// Directed bench for button_toggle_bank (N_CH=2, DEBOUNCE_CYCLES=4,
// ACTIVE_LOW=1, LONG_PRESS_CYCLES=10). Expected output events are queued
// when a stimulus is applied and checked on the cycle they are due; every
// other cycle expects no pulses and the last expected LED value.
module tb_button_toggle_bank;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       CLR_ALL;
  logic [1:0] BUT;
  logic [1:0] LED;
  logic [1:0] PRESS;
  logic [1:0] RELEASE;
  logic [1:0] LONG;

  always #5 CLK = ~CLK;

  button_toggle_bank #(
    .N_CH             (2),
    .DEBOUNCE_CYCLES  (4),
    .ACTIVE_LOW       (1),
    .LONG_PRESS_CYCLES(10)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .BUT    (BUT),
    .CLR_ALL(CLR_ALL),
    .LED    (LED),
    .PRESS  (PRESS),
    .RELEASE(RELEASE),
    .LONG   (LONG)
  );

  typedef struct {
    int unsigned cyc;
    logic [1:0]  press;
    logic [1:0]  rel;
    logic [1:0]  lng;
    logic [1:0]  led;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          total;
  int          bad;
  logic [1:0]  led_exp;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, want);
    end
  endtask

  task automatic push(input int unsigned at, input logic [1:0] p, input logic [1:0] r,
                      input logic [1:0] l, input logic [1:0] led);
    exp_t e;
    e.cyc = at; e.press = p; e.rel = r; e.lng = l; e.led = led;
    sb.push_back(e);
  endtask

  // One clock: sample outputs on the falling edge, retire a due entry.
  task automatic tick();
    exp_t       e;
    logic [1:0] ep = '0;
    logic [1:0] er = '0;
    logic [1:0] el = '0;
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e       = sb.pop_front();
      ep      = e.press;
      er      = e.rel;
      el      = e.lng;
      led_exp = e.led;
    end
    chk("PRESS", PRESS, ep);
    chk("RELEASE", RELEASE, er);
    chk("LONG", LONG, el);
    chk("LED", LED, led_exp);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_LED"}, LED, 2'b00);
    chk({tag, "_PRESS"}, PRESS, 2'b00);
    chk({tag, "_RELEASE"}, RELEASE, 2'b00);
    chk({tag, "_LONG"}, LONG, 2'b00);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    cyc     = 0;
    led_exp = 2'b00;
    RST_N   = 1'b0;
    CLR_ALL = 1'b0;
    BUT     = 2'b11;

    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    RST_N = 1'b1;

    // 1: idle after reset
    ticks(20);

    // 2: clean press / release on channel 0
    BUT[0] = 1'b0;
    push(cyc + 7, 2'b01, 2'b00, 2'b00, 2'b01);
    ticks(7);
    BUT[0] = 1'b1;
    push(cyc + 7, 2'b00, 2'b01, 2'b00, 2'b01);
    ticks(10);

    // 3: bouncing press on channel 1
    BUT[1] = 1'b0; tick();
    BUT[1] = 1'b1; tick();
    BUT[1] = 1'b0; tick();
    BUT[1] = 1'b1; tick();
    BUT[1] = 1'b0;
    push(cyc + 7, 2'b10, 2'b00, 2'b00, 2'b11);
    ticks(7);
    BUT[1] = 1'b1;
    push(cyc + 7, 2'b00, 2'b10, 2'b00, 2'b11);
    ticks(10);

    // 4: simultaneous press on both channels
    BUT = 2'b00;
    push(cyc + 7, 2'b11, 2'b00, 2'b00, 2'b00);
    ticks(7);
    BUT = 2'b11;
    push(cyc + 7, 2'b00, 2'b11, 2'b00, 2'b00);
    ticks(10);

    // 5a: plain CLR_ALL with a lit LED
    BUT[1] = 1'b0;
    push(cyc + 7, 2'b10, 2'b00, 2'b00, 2'b10);
    ticks(7);
    BUT[1] = 1'b1;
    push(cyc + 7, 2'b00, 2'b10, 2'b00, 2'b10);
    ticks(9);
    CLR_ALL = 1'b1;
    push(cyc + 1, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    CLR_ALL = 1'b0;
    ticks(2);

    // 5b: CLR_ALL on the same edge as PRESS[0]
    BUT[0] = 1'b0;
    push(cyc + 7, 2'b01, 2'b00, 2'b00, 2'b00);
    ticks(6);
    CLR_ALL = 1'b1;
    tick();
    CLR_ALL = 1'b0;
    BUT[0] = 1'b1;
    push(cyc + 7, 2'b00, 2'b01, 2'b00, 2'b00);
    ticks(10);

    // 6: reset mid-press, then released while channel 0 is held
    BUT[1] = 1'b0;
    push(cyc + 7, 2'b10, 2'b00, 2'b00, 2'b10);
    ticks(7);
    RST_N = 1'b0;
    BUT   = 2'b10;
    #1;
    led_exp = 2'b00;
    chk_all_zero("async_reset");
    ticks(3);
    RST_N = 1'b1;
    push(cyc + 7, 2'b01, 2'b00, 2'b00, 2'b01);
    ticks(8);
    BUT = 2'b11;
    push(cyc + 7, 2'b00, 2'b01, 2'b00, 2'b01);
    ticks(10);

    // 7: long hold on channel 0
    CLR_ALL = 1'b1;
    push(cyc + 1, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    CLR_ALL = 1'b0;
    ticks(2);
    BUT[0] = 1'b0;
    push(cyc + 7, 2'b01, 2'b00, 2'b00, 2'b01);
`ifdef BUTTON_TOGGLE_BANK_LONG_PRESS_EN
    push(cyc + 17, 2'b00, 2'b00, 2'b01, 2'b00);
`endif
    ticks(30);
    BUT[0] = 1'b1;
`ifdef BUTTON_TOGGLE_BANK_LONG_PRESS_EN
    push(cyc + 7, 2'b00, 2'b01, 2'b00, 2'b00);
`else
    push(cyc + 7, 2'b00, 2'b01, 2'b00, 2'b01);
`endif
    ticks(10);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
